// File: rtl/seqdet_pkg.sv
// Shared types and constants for the 11010 serial pattern detector.
package seqdet_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned PAT_LEN = 5;

  // First-received bit is the MSB.
  localparam logic [PAT_LEN-1:0] PATTERN = 5'b11010;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    S1    = 3'd1,
    S11   = 3'd2,
    S110  = 3'd3,
    S1101 = 3'd4,
    DET   = 3'd5
  } state_e;

endpackage : seqdet_pkg

// File: rtl/seqdet_11010.sv
// Moore detector for the serial pattern 11010, overlapping, one-cycle flag.
module seqdet_11010
  import seqdet_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic cin,
  output logic q
);

  state_e state_q;
  state_e state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Each mismatch falls back to the longest suffix that is still a pattern prefix.
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = (cin == PATTERN[4]) ? S1    : IDLE;
      S1:      state_d = (cin == PATTERN[3]) ? S11   : IDLE;
      S11:     state_d = (cin == PATTERN[2]) ? S110  : S11;
      S110:    state_d = (cin == PATTERN[1]) ? S1101 : IDLE;
      S1101:   state_d = (cin == PATTERN[0]) ? DET   : S11;
      DET:     state_d = cin ? S1 : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    q = 1'b0;
    if (state_q == DET) begin
      q = 1'b1;
    end
  end

endmodule : seqdet_11010

// File: tb/tb_seqdet_11010.sv
// Bench for seqdet_11010: directed scenarios plus random bits against a sliding-window model.
module tb_seqdet_11010;

  logic clk;
  logic rst;
  logic cin;
  logic q;

  int n_tests;
  int n_fail;

  // Last five sampled bits since reset, newest in bit 0.
  logic [4:0] hist;
  logic [4:0] target;

  seqdet_11010 dut (
    .clk (clk),
    .rst (rst),
    .cin (cin),
    .q   (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic model_q();
    return (hist == target);
  endfunction

  // Present a bit on the falling edge, return 1 time unit after the sampling edge.
  task automatic drive(input logic b);
    @(negedge clk);
    cin = b;
    @(posedge clk);
    hist = {hist[3:0], b};
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    hist = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [0:4] bits;
    bits = 5'b11010;
    if (q !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_initial: q=%b expected 0", q);
    end
    n_tests++;
    for (int i = 0; i < 6; i++) begin
      drive(i[0]);
      if (q !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: q=%b expected 0", i, q);
      end
      n_tests++;
    end
    @(negedge clk);
    rst = 1'b0;
    hist = '0;
    for (int i = 0; i < 5; i++) begin
      drive(bits[i]);
    end
    if (q !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_prep_detect: q=%b expected 1", q);
    end
    n_tests++;
    // Asynchronous assert between edges must clear the flag at once.
    #2;
    rst = 1'b1;
    hist = '0;
    #1;
    if (q !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: q=%b expected 0", q);
    end
    n_tests++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [0:9] bits;
    logic [0:9] expq;
    bits = 10'b1101011010;
    expq = 10'b0000100001;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      drive(bits[i]);
      if (q !== expq[i] || q !== model_q()) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: q=%b expected %b", i, q, expq[i]);
      end
      n_tests++;
    end
  endtask

  task automatic test_partial_restart();
    logic [0:7] bits;
    logic [0:7] expq;
    bits = 8'b11011010;
    expq = 8'b00000001;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      drive(bits[i]);
      if (q !== expq[i]) begin
        n_fail++;
        $display("FAIL partial_restart[%0d]: q=%b expected %b", i, q, expq[i]);
      end
      n_tests++;
    end
  endtask

  task automatic test_long_ones();
    logic [0:10] bits;
    logic [0:10] expq;
    bits = 11'b11111010000;
    expq = 11'b00000001000;
    apply_reset();
    for (int i = 0; i < 11; i++) begin
      drive(bits[i]);
      if (q !== expq[i]) begin
        n_fail++;
        $display("FAIL long_ones[%0d]: q=%b expected %b", i, q, expq[i]);
      end
      n_tests++;
    end
  endtask

  task automatic test_near_miss();
    logic [0:8] bits;
    bits = 9'b110011011;
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      drive(bits[i]);
      if (q !== 1'b0) begin
        n_fail++;
        $display("FAIL near_miss[%0d]: q=%b expected 0", i, q);
      end
      n_tests++;
    end
  endtask

  task automatic test_reset_mid_pattern();
    logic [0:3] pre;
    logic [0:5] post;
    logic [0:5] expq;
    pre  = 4'b1101;
    post = 6'b011010;
    expq = 6'b000001;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive(pre[i]);
    end
    #2;
    rst = 1'b1;
    hist = '0;
    #2;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(post[i]);
      if (q !== expq[i]) begin
        n_fail++;
        $display("FAIL reset_mid_pattern[%0d]: q=%b expected %b", i, q, expq[i]);
      end
      n_tests++;
    end
  endtask

  task automatic test_random();
    int hits;
    logic b;
    hits = 0;
    apply_reset();
    for (int i = 0; i < 2000; i++) begin
      // Bias towards 1s so prefixes of 11010 build up often.
      b = ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0;
      drive(b);
      if (q !== model_q()) begin
        n_fail++;
        $display("FAIL random[%0d]: q=%b expected %b", i, q, model_q());
      end
      n_tests++;
      if (model_q()) hits++;
      if ($urandom_range(0, 99) == 0) begin
        #2;
        rst = 1'b1;
        hist = '0;
        #1;
        if (q !== 1'b0) begin
          n_fail++;
          $display("FAIL random_async_reset[%0d]: q=%b expected 0", i, q);
        end
        n_tests++;
        rst = 1'b0;
      end
    end
    if (hits < 10) begin
      n_fail++;
      $display("FAIL random_coverage: hits=%0d expected at least 10", hits);
    end
    n_tests++;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    target  = 5'b11010;
    hist    = '0;
    rst     = 1'b1;
    cin     = 1'b0;
    #1;
    test_reset();
    test_back_to_back();
    test_partial_restart();
    test_long_ones();
    test_near_miss();
    test_reset_mid_pattern();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_seqdet_11010
